// File: rtl/brick_pkg.sv
// brick_pkg
//   Shared constants, types and helpers for the brick playfield. Used by the
//   renderer, the census block and the ball/brick update logic so that all
//   of them agree on the packed brick-array layout and the level palette.
package brick_pkg;

    localparam int unsigned H          = 640;   // active width in pixels
    localparam int unsigned V          = 480;   // active height in pixels
    localparam int unsigned BRICK_W    = 32;    // brick width, power of two
    localparam int unsigned BRICK_H    = 20;    // brick height
    localparam int unsigned COLS       = 20;    // bricks per row
    localparam int unsigned ROWS       = 24;    // brick rows
    localparam int unsigned LVL_BITS   = 3;     // bits per brick level
    localparam int unsigned NUM_BRICKS = 480;   // COLS * ROWS
    localparam int unsigned BRICK_BITS = LVL_BITS * NUM_BRICKS;

    typedef logic [LVL_BITS-1:0] lvl_t;
    typedef logic [11:0]         rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } census_state_e;

    // Palette for a live brick interior; level 0 (empty) maps to black.
    function automatic rgb_t level_rgb(input lvl_t lvl);
        rgb_t rgb;
        case (lvl)
            3'd1:    rgb = 12'hF00;
            3'd2:    rgb = 12'hF80;
            3'd3:    rgb = 12'hFF0;
            3'd4:    rgb = 12'h0F0;
            3'd5:    rgb = 12'h0FF;
            3'd6:    rgb = 12'h00F;
            3'd7:    rgb = 12'hFFF;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

    // Bit offset of cell (col,row) in the packed array: 3*col + 60*row.
    function automatic logic [10:0] cell_index(input logic [4:0] col, input logic [4:0] row);
        return 11'(LVL_BITS) * (11'(col) + 11'(COLS) * 11'(row));
    endfunction

endpackage

// File: rtl/brick_census.sv
// brick_census
//   Once per frame, snapshots the brick array and walks it one cell per
//   clock, counting live bricks and summing their levels. The totals are
//   published together with a one-cycle count_valid_o pulse.
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   bricks_i          packed brick levels (3 bits per cell)
//   frame_start_i     starts a scan when the FSM is idle
//   brick_count_o     live bricks in the last completed scan
//   hp_total_o        sum of levels in the last completed scan
//   level_clear_o     last completed scan found no live bricks
//   count_valid_o     one-cycle pulse when the three results update
module brick_census
    import brick_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BRICK_BITS-1:0] bricks_i,
    input  logic                  frame_start_i,
    output logic [8:0]            brick_count_o,
    output logic [11:0]           hp_total_o,
    output logic                  level_clear_o,
    output logic                  count_valid_o
);

    census_state_e         state_q, state_d;
    logic [8:0]            idx_q, idx_d;
    logic [BRICK_BITS-1:0] snap_q, snap_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [11:0]           hp_q, hp_d;
    logic [8:0]            brick_count_q, brick_count_d;
    logic [11:0]           hp_total_q, hp_total_d;
    logic                  level_clear_q, level_clear_d;
    logic                  count_valid_q, count_valid_d;

    logic [10:0]           scan_base;
    lvl_t                  scan_lvl;

    assign scan_base = 11'(idx_q) * 11'(LVL_BITS);
    assign scan_lvl  = snap_q[scan_base +: LVL_BITS];

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        cnt_d         = cnt_q;
        hp_d          = hp_q;
        brick_count_d = brick_count_q;
        hp_total_d    = hp_total_q;
        level_clear_d = level_clear_q;
        count_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    snap_d  = bricks_i;
                    idx_d   = '0;
                    cnt_d   = '0;
                    hp_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                cnt_d = cnt_q + {8'd0, scan_lvl != '0};
                hp_d  = hp_q + {9'd0, scan_lvl};
                if (idx_q == 9'(NUM_BRICKS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
            DONE: begin
                brick_count_d = cnt_q;
                hp_total_d    = hp_q;
                level_clear_d = (cnt_q == '0);
                count_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the snapshot is a wide register rather than a RAM, so it takes
    // the reset like any other flop and reads as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            snap_q        <= '0;
            cnt_q         <= '0;
            hp_q          <= '0;
            brick_count_q <= '0;
            hp_total_q    <= '0;
            level_clear_q <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            cnt_q         <= cnt_d;
            hp_q          <= hp_d;
            brick_count_q <= brick_count_d;
            hp_total_q    <= hp_total_d;
            level_clear_q <= level_clear_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign brick_count_o = brick_count_q;
    assign hp_total_o    = hp_total_q;
    assign level_clear_o = level_clear_q;
    assign count_valid_o = count_valid_q;

endmodule

// File: rtl/brick_render.sv
// brick_render
//   Turns the packed brick array into VGA pixels through a free-running
//   2-stage pipeline indexed by the VGA h/v counters, and hosts the
//   per-frame brick census.
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   bricks            packed brick levels, cell (c,r) at [3c+60r +: 3]
//   h_cnt, v_cnt      current pixel coordinates
//   valid             display-active qualifier
//   frame_start       one-cycle pulse at vertical blank start
//   pixel_rgb         4:4:4 colour, two clocks after h_cnt/v_cnt
//   pixel_hit         pixel lies on a live brick, aligned with pixel_rgb
//   brick_count       live bricks from the last completed census
//   hp_total          sum of levels from the last completed census
//   level_clear       last completed census found no bricks
//   count_valid       pulse when the census outputs update
module brick_render
    import brick_pkg::*;
#(
    parameter int unsigned H       = brick_pkg::H,
    parameter int unsigned V       = brick_pkg::V,
    parameter int unsigned BRICK_W = brick_pkg::BRICK_W,
    parameter int unsigned BRICK_H = brick_pkg::BRICK_H,
    parameter int unsigned COLS    = brick_pkg::COLS,
    parameter int unsigned ROWS    = brick_pkg::ROWS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [brick_pkg::LVL_BITS*COLS*ROWS-1:0] bricks,
    input  logic [9:0]                           h_cnt,
    input  logic [9:0]                           v_cnt,
    input  logic                                 valid,
    input  logic                                 frame_start,
    output logic [11:0]                          pixel_rgb,
    output logic                                 pixel_hit,
    output logic [8:0]                           brick_count,
    output logic [11:0]                          hp_total,
    output logic                                 level_clear,
    output logic                                 count_valid
);

    // Stage 1: cell coordinates and in-cell offsets.
    logic [4:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [4:0] xo_q, xo_d;
    logic [4:0] yo_q, yo_d;
    logic       in_range_q, in_range_d;
    logic [4:0] row_raw;

    // Stage 2: colour and hit flag.
    logic [11:0] rgb_q, rgb_d;
    logic        hit_q, hit_d;
    lvl_t        pix_lvl;

    always_comb begin
        in_range_d = valid && (h_cnt < 10'(H)) && (v_cnt < 10'(V));
        row_raw    = 5'(v_cnt / 10'(BRICK_H));
        xo_d       = h_cnt[4:0];
        yo_d       = 5'(v_cnt - 10'(row_raw) * 10'(BRICK_H));
        // Out-of-range coordinates are parked on cell 0 so the stage-2
        // select always stays inside the array; the level is masked anyway.
        col_d      = '0;
        row_d      = '0;
        if (in_range_d) begin
            col_d = 5'(h_cnt >> $clog2(BRICK_W));
            row_d = row_raw;
        end
    end

    always_comb begin
        pix_lvl = in_range_q ? bricks[cell_index(col_q, row_q) +: LVL_BITS] : '0;
        hit_d   = (pix_lvl != '0);
        if (!hit_d) begin
            rgb_d = 12'h000;
        end else if (xo_q == '0 || yo_q == '0) begin
            rgb_d = 12'h444;
        end else begin
            rgb_d = level_rgb(pix_lvl);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            xo_q       <= '0;
            yo_q       <= '0;
            in_range_q <= 1'b0;
            rgb_q      <= '0;
            hit_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            xo_q       <= xo_d;
            yo_q       <= yo_d;
            in_range_q <= in_range_d;
            rgb_q      <= rgb_d;
            hit_q      <= hit_d;
        end
    end

    assign pixel_rgb = rgb_q;
    assign pixel_hit = hit_q;

    brick_census u_census (
        .clk           (clk),
        .rst           (rst),
        .bricks_i      (bricks),
        .frame_start_i (frame_start),
        .brick_count_o (brick_count),
        .hp_total_o    (hp_total),
        .level_clear_o (level_clear),
        .count_valid_o (count_valid)
    );

endmodule

// File: tb/tb_brick_render.sv
module tb_brick_render;

    logic         clk;
    logic         rst;
    logic [1439:0] bricks;
    logic [9:0]   h_cnt;
    logic [9:0]   v_cnt;
    logic         valid;
    logic         frame_start;
    logic [11:0]  pixel_rgb;
    logic         pixel_hit;
    logic [8:0]   brick_count;
    logic [11:0]  hp_total;
    logic         level_clear;
    logic         count_valid;

    int total = 0;
    int bad   = 0;

    brick_render dut (
        .clk         (clk),
        .rst         (rst),
        .bricks      (bricks),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .frame_start (frame_start),
        .pixel_rgb   (pixel_rgb),
        .pixel_hit   (pixel_hit),
        .brick_count (brick_count),
        .hp_total    (hp_total),
        .level_clear (level_clear),
        .count_valid (count_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cell(input int col, input int row, input logic [2:0] lvl);
        bricks[3*col + 60*row +: 3] = lvl;
    endtask

    // Drive a coordinate at a falling edge and check the pixel two clocks on.
    task automatic pix(input string tag, input int h, input int v, input logic vld,
                       input logic [11:0] rgb, input logic hit);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = vld;
        repeat (2) @(negedge clk);
        check({tag, "_rgb"}, 32'(pixel_rgb), 32'(rgb));
        check({tag, "_hit"}, 32'(pixel_hit), 32'(hit));
    endtask

    // Pulse frame_start, then watch 600 falling edges. Optionally zero the
    // array and re-pulse frame_start at edge zap_at while the scan runs.
    task automatic run_scan(input int zap_at, output int lat, output int pulses);
        lat    = 0;
        pulses = 0;
        frame_start = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            frame_start = (n == zap_at);
            if (n == zap_at) bricks = '0;
            if (count_valid) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
        frame_start = 1'b0;
    endtask

    int lat;
    int pulses;

    initial begin
        rst         = 1'b1;
        bricks      = '0;
        h_cnt       = '0;
        v_cnt       = '0;
        valid       = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rgb",   32'(pixel_rgb),   32'h000);
        check("rst_hit",   32'(pixel_hit),   32'd0);
        check("rst_count", 32'(brick_count), 32'd0);
        check("rst_hp",    32'(hp_total),    32'd0);
        check("rst_clear", 32'(level_clear), 32'd0);
        check("rst_cv",    32'(count_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single brick (col 2, row 1) = 3
        set_cell(2, 1, 3'd3);
        pix("cell_in",     70, 25, 1'b1, 12'hFF0, 1'b1);
        pix("border_x",    64, 25, 1'b1, 12'h444, 1'b1);
        pix("border_y",    70, 20, 1'b1, 12'h444, 1'b1);
        pix("cell_in2",    70, 25, 1'b1, 12'hFF0, 1'b1);
        // Latency: one clock after moving off the brick the old pixel remains
        h_cnt = 10'd100;
        @(negedge clk);
        check("lat_old_rgb", 32'(pixel_rgb), 32'hFF0);
        @(negedge clk);
        check("lat_new_rgb", 32'(pixel_rgb), 32'h000);
        check("lat_new_hit", 32'(pixel_hit), 32'd0);
        set_cell(0, 0, 3'd6);
        pix("lvl6",        5, 5, 1'b1, 12'h00F, 1'b1);

        // Fully populated array, level 7 everywhere
        bricks = '1;
        pix("full_in",     100, 30, 1'b1, 12'hFFF, 1'b1);
        pix("corner",      639, 479, 1'b1, 12'hFFF, 1'b1);
        pix("h700",        700, 25, 1'b1, 12'h000, 1'b0);
        pix("h640",        640, 25, 1'b1, 12'h000, 1'b0);
        pix("v480",        10, 480, 1'b1, 12'h000, 1'b0);
        pix("invalid",     70, 25, 1'b0, 12'h000, 1'b0);

        // Full census
        run_scan(0, lat, pulses);
        check("full_lat",    32'(lat),         32'd482);
        check("full_pulses", 32'(pulses),      32'd1);
        check("full_count",  32'(brick_count), 32'd480);
        check("full_hp",     32'(hp_total),    32'd3360);
        check("full_clear",  32'(level_clear), 32'd0);

        // Empty census, outputs hold afterwards
        bricks = '0;
        run_scan(0, lat, pulses);
        check("empty_lat",   32'(lat),         32'd482);
        check("empty_count", 32'(brick_count), 32'd0);
        check("empty_hp",    32'(hp_total),    32'd0);
        check("empty_clear", 32'(level_clear), 32'd1);
        repeat (10) @(negedge clk);
        check("hold_cv",     32'(count_valid), 32'd0);
        check("hold_clear",  32'(level_clear), 32'd1);
        check("hold_count",  32'(brick_count), 32'd0);

        // Snapshot isolation and ignored frame_start during the scan
        set_cell(0, 0, 3'd1);
        set_cell(5, 3, 3'd2);
        set_cell(10, 10, 3'd3);
        set_cell(2, 20, 3'd4);
        set_cell(19, 23, 3'd5);
        run_scan(100, lat, pulses);
        check("snap_lat",    32'(lat),         32'd482);
        check("snap_pulses", 32'(pulses),      32'd1);
        check("snap_count",  32'(brick_count), 32'd5);
        check("snap_hp",     32'(hp_total),    32'd15);
        check("snap_clear",  32'(level_clear), 32'd0);

        // Reset in the middle of a scan
        bricks = '1;
        frame_start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            frame_start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(brick_count), 32'd0);
        check("mid_rst_hp",    32'(hp_total),    32'd0);
        check("mid_rst_clear", 32'(level_clear), 32'd0);
        check("mid_rst_cv",    32'(count_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (count_valid) pulses++;
        end
        check("mid_rst_pulses", 32'(pulses),      32'd0);
        check("mid_rst_hold",   32'(brick_count), 32'd0);

        // Next scan after reset runs normally
        run_scan(0, lat, pulses);
        check("post_lat",   32'(lat),         32'd482);
        check("post_count", 32'(brick_count), 32'd480);
        check("post_hp",    32'(hp_total),    32'd3360);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
